// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampled I2C target with a byte-wide register file.
// SCL/SDA are synchronised and edge-detected on clk. A pointer byte written
// after the address selects the register; further write bytes store and
// auto-increment, reads shift out and auto-increment on each master ACK.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free or not yet addressed
// ADDR      | shifting in address + R/W bit
// ADDR_ACK  | pull SDA for the address ACK slot, then branch on R/W
// PTR       | shifting in the register pointer byte
// PTR_ACK   | ACK slot for the pointer byte
// WDATA     | shifting in a write data byte
// WDATA_ACK | ACK slot for a write data byte
// RDATA     | shifting out reg[ptr], MSB first
// RDATA_ACK | sampling the master's ACK/NACK
// IGNORE    | not addressed or read ended; wait for START/STOP
module i2c_target_regs #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic [7:0]                  wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [7:0]                  rd_data,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic                   w_start, w_stop;

  state_t                 r_state;
  logic [7:0]             r_shift;
  logic [3:0]             r_bitcnt;
  logic                   r_ack_phase;
  logic                   r_rw;
  logic [PW-1:0]          r_ptr;
  logic [7:0]             r_regs [NUM_REGS];

  logic [7:0]             w_byte;
  logic [PW-1:0]          w_ptr_inc;
  logic [7:0]             w_cur, w_next;

  // Synchronise the pins and keep a one-cycle-delayed copy for edge detection.
  // Reset to 1 so a released bus does not look like an edge after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl &  r_scl_d;
  assign w_sda_rise =  w_sda & ~r_sda_d;
  assign w_sda_fall = ~w_sda &  r_sda_d;
  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;

  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_ptr_inc = r_ptr + PW'(1);
  assign w_cur     = r_regs[r_ptr];
  assign w_next    = r_regs[w_ptr_inc];
  assign rd_data   = r_regs[rd_idx];

  // Protocol FSM, register file and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_bitcnt    <= 4'd0;
      r_ack_phase <= 1'b0;
      r_rw        <= 1'b0;
      r_ptr       <= '0;
      sda_oe      <= 1'b0;
      wr_stb      <= 1'b0;
      wr_idx      <= '0;
      wr_data     <= 8'h00;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      wr_stb <= 1'b0;
      if (w_start) begin
        r_state     <= S_ADDR;
        r_bitcnt    <= 4'd0;
        r_ack_phase <= 1'b0;
        sda_oe      <= 1'b0;
      end else if (w_stop) begin
        r_state     <= S_IDLE;
        r_ack_phase <= 1'b0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt <= 4'd0;
              if (w_byte[7:1] == ADDR) begin
                r_state <= S_ADDR_ACK;
                r_rw    <= w_byte[0];
                busy    <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
                busy    <= 1'b0;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          // The first falling edge opens the ACK slot, the second closes it.
          S_ADDR_ACK: if (w_scl_fall) begin
            if (!r_ack_phase) begin
              sda_oe      <= 1'b1;
              r_ack_phase <= 1'b1;
            end else begin
              r_ack_phase <= 1'b0;
              if (r_rw) begin
                // Closing the ACK slot is also where bit 7 goes out.
                r_state  <= S_RDATA;
                r_shift  <= {w_cur[6:0], 1'b0};
                sda_oe   <= ~w_cur[7];
                r_bitcnt <= 4'd1;
              end else begin
                r_state  <= S_PTR;
                sda_oe   <= 1'b0;
                r_bitcnt <= 4'd0;
              end
            end
          end
          S_PTR: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt <= 4'd0;
              r_ptr    <= w_byte[PW-1:0];
              r_state  <= S_PTR_ACK;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          S_PTR_ACK, S_WDATA_ACK: if (w_scl_fall) begin
            if (!r_ack_phase) begin
              sda_oe      <= 1'b1;
              r_ack_phase <= 1'b1;
            end else begin
              r_ack_phase <= 1'b0;
              sda_oe      <= 1'b0;
              r_bitcnt    <= 4'd0;
              r_state     <= S_WDATA;
            end
          end
          S_WDATA: if (w_scl_rise) begin
            r_shift <= w_byte;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt      <= 4'd0;
              r_regs[r_ptr] <= w_byte;
              wr_stb        <= 1'b1;
              wr_idx        <= r_ptr;
              wr_data       <= w_byte;
              r_ptr         <= w_ptr_inc;
              r_state       <= S_WDATA_ACK;
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          // r_bitcnt counts bits already driven; at 8 the next fall frees SDA.
          S_RDATA: if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              sda_oe   <= 1'b0;
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA_ACK;
            end else begin
              sda_oe   <= ~r_shift[7];
              r_shift  <= {r_shift[6:0], 1'b0};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          S_RDATA_ACK: if (w_scl_rise) begin
            r_ptr <= w_ptr_inc;
            if (!w_sda) begin
              r_state  <= S_RDATA;
              r_shift  <= w_next;
              r_bitcnt <= 4'd0;
            end else begin
              r_state <= S_IGNORE;
              busy    <= 1'b0;
            end
          end
          S_IDLE, S_IGNORE: sda_oe <= 1'b0;
          default: begin
            r_state <= S_IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master with an
// open-drain SDA line, monitors for write strobes and SDA activity.
module tb_i2c_target_regs;

  localparam int         NR = 16;
  localparam logic [7:0] RV = 8'h3C;
  localparam int         Q  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] rd_idx = 4'd0;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_idx;
  logic [7:0] wr_data, rd_data;
  logic       sda_line;

  int n_tests = 0;
  int n_fail  = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(
    .ADDR(7'h50), .NUM_REGS(NR), .SYNC_STAGES(2), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy)
  );

  // monitors
  int         wr_cnt = 0;
  int         oe_cnt = 0;
  int         busy_cnt = 0;
  int         oe_viol = 0;
  logic [3:0] log_idx [64];
  logic [7:0] log_data [64];
  logic       prev_oe = 1'b0;
  logic       prev_scl = 1'b1;

  always @(negedge clk) begin
    if (wr_stb) begin
      if (wr_cnt < 64) begin
        log_idx[wr_cnt]  <= wr_idx;
        log_data[wr_cnt] <= wr_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (rst_n && scl_m && prev_scl && (sda_oe !== prev_oe)) oe_viol <= oe_viol + 1;
    prev_oe  <= sda_oe;
    prev_scl <= scl_m;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe got %b exp 0", sda_oe); end
    n_tests++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL rst_wr_stb got %b exp 0", wr_stb); end
    n_tests++; if (wr_idx !== 4'd0) begin n_fail++; $display("FAIL rst_wr_idx got %h exp 0", wr_idx); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data got %h exp 00", wr_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    tick(5);
    for (int i = 0; i < NR; i++) begin
      rd_idx = 4'(i); #1;
      n_tests++; if (rd_data !== RV) begin n_fail++; $display("FAIL rst_reg%0d got %h exp %h", i, rd_data, RV); end
    end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h03, a1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_mid got %b exp 1", busy); end
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    i2c_stop();
    tick(5);
    n_tests++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL wr_acks got %b exp 0000", {a0, a1, a2, a3}); end
    n_tests++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL wr_strobes got %0d exp 2", wr_cnt - w0); end
    n_tests++; if ({log_idx[w0], log_data[w0]} !== {4'd3, 8'h11}) begin n_fail++; $display("FAIL wr_first got %h/%h exp 3/11", log_idx[w0], log_data[w0]); end
    n_tests++; if ({log_idx[w0+1], log_data[w0+1]} !== {4'd4, 8'h22}) begin n_fail++; $display("FAIL wr_second got %h/%h exp 4/22", log_idx[w0+1], log_data[w0+1]); end
    n_tests++; if ({wr_idx, wr_data} !== {4'd4, 8'h22}) begin n_fail++; $display("FAIL wr_held got %h/%h exp 4/22", wr_idx, wr_data); end
    rd_idx = 4'd4; #1;
    n_tests++; if (rd_data !== 8'h22) begin n_fail++; $display("FAIL wr_rd4 got %h exp 22", rd_data); end
    rd_idx = 4'd3; #1;
    n_tests++; if (rd_data !== 8'h11) begin n_fail++; $display("FAIL wr_rd3 got %h exp 11", rd_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_read();
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    logic [7:0] d0, d1, d2;
    // preload reg15/reg0 through a wrapping write burst
    i2c_start();
    write_byte(8'hA0, a0); write_byte(8'h0F, a1);
    write_byte(8'hAB, a2); write_byte(8'hCD, a3);
    i2c_stop();
    tick(5);
    n_tests++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_fail++; $display("FAIL rd_preload_acks got %b exp 0000", {a0, a1, a2, a3}); end
    rd_idx = 4'd0; #1;
    n_tests++; if (rd_data !== 8'hCD) begin n_fail++; $display("FAIL rd_wrap_reg0 got %h exp CD", rd_data); end
    i2c_start();
    write_byte(8'hA0, a4); write_byte(8'h0F, a5);
    i2c_start();
    write_byte(8'hA1, a6);
    read_byte(d0, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_mid got %b exp 1", busy); end
    read_byte(d1, 1'b1);
    n_tests++; if ({a4, a5, a6} !== 3'b000) begin n_fail++; $display("FAIL rd_acks got %b exp 000", {a4, a5, a6}); end
    n_tests++; if (d0 !== 8'hAB) begin n_fail++; $display("FAIL rd_byte0 got %h exp AB", d0); end
    n_tests++; if (d1 !== 8'hCD) begin n_fail++; $display("FAIL rd_byte1 got %h exp CD", d1); end
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_release_nack got %b exp 0", sda_oe); end
    i2c_stop();
    tick(5);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end got %b exp 0", busy); end
    // pointer retained: 15 -> 0 -> 1 after the two reads
    i2c_start();
    write_byte(8'hA1, a7);
    read_byte(d2, 1'b1);
    i2c_stop();
    tick(5);
    n_tests++; if (a7 !== 1'b0) begin n_fail++; $display("FAIL rd_keep_ack got %b exp 0", a7); end
    n_tests++; if (d2 !== RV) begin n_fail++; $display("FAIL rd_keep_ptr got %h exp %h", d2, RV); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1, a2;
    int w0, o0, b0;
    w0 = wr_cnt; o0 = oe_cnt; b0 = busy_cnt;
    i2c_start();
    write_byte(8'h84, a0);
    write_byte(8'h99, a1);
    i2c_stop();
    i2c_start();
    write_byte(8'hA2, a2);
    i2c_stop();
    tick(5);
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wa_nacks got %b exp 111", {a0, a1, a2}); end
    n_tests++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL wa_sda_oe got %0d exp 0", oe_cnt - o0); end
    n_tests++; if (busy_cnt - b0 !== 0) begin n_fail++; $display("FAIL wa_busy got %0d exp 0", busy_cnt - b0); end
    n_tests++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL wa_wr_stb got %0d exp 0", wr_cnt - w0); end
  endtask

  task automatic test_stop_mid();
    logic a0, a1;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h05, a1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    tick(5);
    n_tests++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL sm_acks got %b exp 00", {a0, a1}); end
    n_tests++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL sm_wr_stb got %0d exp 0", wr_cnt - w0); end
    rd_idx = 4'd5; #1;
    n_tests++; if (rd_data !== RV) begin n_fail++; $display("FAIL sm_reg5 got %h exp %h", rd_data, RV); end
    n_tests++; if ({busy, sda_oe} !== 2'b00) begin n_fail++; $display("FAIL sm_idle got %b exp 00", {busy, sda_oe}); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, a3, a4, a5;
    int w0;
    i2c_start();
    write_byte(8'hA0, a0); write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    // reg3 = 0x11, bit 7 is 0 so the target is pulling SDA now
    n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rr_driving got %b exp 1", sda_oe); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rr_release got %b exp 0", sda_oe); end
    tick(3);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    n_tests++; if ({wr_idx, wr_data, busy} !== 13'd0) begin n_fail++; $display("FAIL rr_outputs got %h/%h/%b exp 0/00/0", wr_idx, wr_data, busy); end
    for (int i = 0; i < NR; i++) begin
      rd_idx = 4'(i); #1;
      n_tests++; if (rd_data !== RV) begin n_fail++; $display("FAIL rr_reg%0d got %h exp %h", i, rd_data, RV); end
    end
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'hA0, a3); write_byte(8'h07, a4); write_byte(8'h55, a5);
    i2c_stop();
    tick(5);
    n_tests++; if ({a3, a4, a5} !== 3'b000) begin n_fail++; $display("FAIL rr_after_acks got %b exp 000", {a3, a4, a5}); end
    n_tests++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL rr_after_strobes got %0d exp 1", wr_cnt - w0); end
    n_tests++; if ({log_idx[w0], log_data[w0]} !== {4'd7, 8'h55}) begin n_fail++; $display("FAIL rr_after_write got %h/%h exp 7/55", log_idx[w0], log_data[w0]); end
    rd_idx = 4'd7; #1;
    n_tests++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL rr_reg7 got %h exp 55", rd_data); end
  endtask

  task automatic test_oe_stable();
    n_tests++; if (oe_viol !== 0) begin n_fail++; $display("FAIL oe_stable_scl_high got %0d changes exp 0", oe_viol); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_stop_mid();
    test_reset_mid_read();
    test_oe_stable();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
